// File: rtl/display_timing.sv
// display_timing: VGA-style raster timing generator.
// A prescaler divides clk down to the pixel rate; column and row counters
// walk the full raster (active + porches + sync), and the video/sync
// qualifiers are registered from the counters' next values so every output
// changes on the same clk edge as the position it describes.
//
// pix_tick is high for the single clk cycle in which the prescaler sits at
// CLK_DIV-1. The counters advance on the edge that ends that cycle.
// frame_start is high for the one clk cycle that follows the edge on which
// the position wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0).
module display_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] pixel_column,
    output logic [9:0] pixel_row,
    output logic       video_on,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       frame_start
);

    // Raster geometry.
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Prescaler width; at least one bit even for the smallest legal divider.
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END    = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_next;
    logic [9:0]    column_next;
    logic [9:0]    row_next;
    logic          frame_wrap;
    logic          video_next;
    logic          hsync_next;
    logic          vsync_next;

    // Strobe is a pure decode of the prescaler, so it drops to 0 the moment
    // reset clears the prescaler.
    assign pix_tick = (prescaler == PRE_LAST);

    // Prescaler next value: free-running 0..CLK_DIV-1.
    always_comb begin
        prescaler_next = prescaler + PW'(1);
        if (prescaler == PRE_LAST) begin
            prescaler_next = '0;
        end
    end

    // Position next value: column advances on each pixel strobe, row only
    // on a column wrap; a double wrap lands directly on (0,0).
    always_comb begin
        column_next = pixel_column;
        row_next    = pixel_row;
        frame_wrap  = 1'b0;
        if (pix_tick) begin
            if (pixel_column == H_LAST) begin
                column_next = '0;
                if (pixel_row == V_LAST) begin
                    row_next   = '0;
                    frame_wrap = 1'b1;
                end else begin
                    row_next = pixel_row + 10'd1;
                end
            end else begin
                column_next = pixel_column + 10'd1;
            end
        end
    end

    // Qualifiers decoded from the next position so their flops line up with
    // the counter flops; syncs are active-low.
    always_comb begin
        video_next = (column_next < H_VIS_END) && (row_next < V_VIS_END);
        hsync_next = !((column_next >= H_SYNC_START) && (column_next < H_SYNC_END));
        vsync_next = !((row_next >= V_SYNC_START) && (row_next < V_SYNC_END));
    end

    // All timing state; reset forces the idle raster asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler    <= '0;
            pixel_column <= '0;
            pixel_row    <= '0;
            video_on     <= 1'b0;
            horiz_sync   <= 1'b1;
            vert_sync    <= 1'b1;
            frame_start  <= 1'b0;
        end else begin
            prescaler    <= prescaler_next;
            pixel_column <= column_next;
            pixel_row    <= row_next;
            video_on     <= video_next;
            horiz_sync   <= hsync_next;
            vert_sync    <= vsync_next;
            frame_start  <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_display_timing.sv
// tb_display_timing: checks display_timing against a closed-form model of the
// raster. The model derives every output from the number of clk edges since
// reset release: pixel index = edges / CLK_DIV, column = index mod H_TOTAL,
// row = (index / H_TOTAL) mod V_TOTAL. A small geometry keeps frames short.
module tb_display_timing;

    localparam int CLK_DIV = 4;
    localparam int HA  = 10;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 2;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int LINE  = CLK_DIV * HT;
    localparam int FRAME = LINE * VT;

    // Clock / reset.
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       pix_tick;
    logic [9:0] pixel_column;
    logic [9:0] pixel_row;
    logic       video_on;
    logic       horiz_sync;
    logic       vert_sync;
    logic       frame_start;

    display_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(HA),
        .H_FP    (HFP),
        .H_SYNC  (HS),
        .H_BP    (HBP),
        .V_ACTIVE(VA),
        .V_FP    (VFP),
        .V_SYNC  (VS),
        .V_BP    (VBP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_tick    (pix_tick),
        .pixel_column(pixel_column),
        .pixel_row   (pixel_row),
        .video_on    (video_on),
        .horiz_sync  (horiz_sync),
        .vert_sync   (vert_sync),
        .frame_start (frame_start)
    );

    // Observed outputs packed as {tick, column, row, video, hsync, vsync, frame}.
    logic [24:0] dut_vec;
    assign dut_vec = {pix_tick, pixel_column, pixel_row, video_on,
                      horiz_sync, vert_sync, frame_start};

    int t;                 // clk edges since reset release; -1 while in reset
    int vectors     = 0;
    int miscompares = 0;

    // Reference model; t < 0 means reset is held.
    function automatic logic [24:0] model(input int tt);
        int   p;
        int   col;
        int   row;
        logic tick;
        logic vid;
        logic hs_n;
        logic vs_n;
        logic fs;
        if (tt < 0) begin
            return {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        end
        p    = tt / CLK_DIV;
        col  = p % HT;
        row  = (p / HT) % VT;
        tick = ((tt % CLK_DIV) == CLK_DIV - 1);
        if (tt == 0) begin
            vid  = 1'b0;
            hs_n = 1'b1;
            vs_n = 1'b1;
            fs   = 1'b0;
        end else begin
            vid  = (col < HA) && (row < VA);
            hs_n = !((col >= HA + HFP) && (col < HA + HFP + HS));
            vs_n = !((row >= VA + VFP) && (row < VA + VFP + VS));
            fs   = ((tt % FRAME) == 0);
        end
        return {tick, 10'(col), 10'(row), vid, hs_n, vs_n, fs};
    endfunction

    // Advance one clk edge and settle just after it.
    task automatic tick_clk();
        @(posedge clk);
        if (t >= 0) t++;
        #1;
    endtask

    // Release reset between edges; the cycle that follows is cycle 0.
    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        t = 0;
    endtask

    task automatic test_reset();
        logic [24:0] exp;
        reset = 1'b1;
        t = -1;
        #2;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            exp = model(-1);
            vectors++;
            if (dut_vec !== exp) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d: got {tick,col,row,vid,hs,vs,fs}=%h want %h", i, dut_vec, exp);
            end
        end
        release_reset();
        exp = model(0);
        vectors++;
        if (dut_vec !== exp) begin
            miscompares++;
            $display("FAIL reset_exit: got %h want %h", dut_vec, exp);
        end
    endtask

    // First 8 cycles: strobe in cycles 3 and 7, column 0 -> 1 -> 2.
    task automatic test_first_cycles();
        logic [24:0] exp;
        int          ticks_at;
        ticks_at = 0;
        for (int i = 0; i < 8; i++) begin
            tick_clk();
            exp = model(t);
            vectors++;
            if (dut_vec !== exp) begin
                miscompares++;
                $display("FAIL first_cycles t=%0d: got %h want %h", t, dut_vec, exp);
            end
            if (pix_tick) ticks_at = ticks_at + t;
        end
        vectors++;
        if (ticks_at !== 3 + 7 || pixel_column !== 10'd2) begin
            miscompares++;
            $display("FAIL first_ticks: tick cycle sum=%0d col=%0d want sum=10 col=2", ticks_at, pixel_column);
        end
    endtask

    // One full line: hsync low for HS pixels starting at HA+HFP, video off at HA.
    task automatic test_line();
        logic [24:0] exp;
        int          hs_low;
        int          hs_first_col;
        int          vid_fall_col;
        logic        prev_vid;
        logic        prev_hs;
        hs_low       = 0;
        hs_first_col = -1;
        vid_fall_col = -1;
        prev_vid     = video_on;
        prev_hs      = horiz_sync;
        for (int i = 0; i < LINE; i++) begin
            tick_clk();
            exp = model(t);
            vectors++;
            if (dut_vec !== exp) begin
                miscompares++;
                $display("FAIL line t=%0d: got %h want %h", t, dut_vec, exp);
            end
            if (!horiz_sync) hs_low++;
            if (prev_hs && !horiz_sync) hs_first_col = int'(pixel_column);
            if (prev_vid && !video_on) vid_fall_col = int'(pixel_column);
            prev_hs  = horiz_sync;
            prev_vid = video_on;
        end
        vectors++;
        if (hs_low !== HS * CLK_DIV || hs_first_col !== HA + HFP || vid_fall_col !== HA) begin
            miscompares++;
            $display("FAIL line_shape: hs_low=%0d hs_col=%0d vid_fall=%0d want %0d %0d %0d",
                     hs_low, hs_first_col, vid_fall_col, HS * CLK_DIV, HA + HFP, HA);
        end
    endtask

    // Two full frames: every cycle against the model plus aggregate counts.
    task automatic test_frames();
        logic [24:0] exp;
        int          fs_count;
        int          vs_low;
        int          tick_count;
        int          bad_pulse;
        logic        prev_fs;
        logic [9:0]  prev_col;
        logic [9:0]  prev_row;
        fs_count   = 0;
        vs_low     = 0;
        tick_count = 0;
        bad_pulse  = 0;
        prev_fs    = frame_start;
        prev_col   = pixel_column;
        prev_row   = pixel_row;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick_clk();
            exp = model(t);
            vectors++;
            if (dut_vec !== exp) begin
                miscompares++;
                $display("FAIL frames t=%0d: got %h want %h", t, dut_vec, exp);
            end
            if (frame_start) begin
                fs_count++;
                if (prev_fs) bad_pulse++;
                if (pixel_column !== 10'd0 || pixel_row !== 10'd0 ||
                    prev_col !== 10'(HT - 1) || prev_row !== 10'(VT - 1)) bad_pulse++;
            end
            if (!vert_sync) vs_low++;
            if (pix_tick) tick_count++;
            if (video_on && (pixel_column >= 10'(HA) || pixel_row >= 10'(VA))) bad_pulse++;
            if (pixel_column >= 10'(HT) || pixel_row >= 10'(VT)) bad_pulse++;
            prev_fs  = frame_start;
            prev_col = pixel_column;
            prev_row = pixel_row;
        end
        vectors++;
        if (fs_count !== 2 || vs_low !== 2 * VS * LINE ||
            tick_count !== 2 * FRAME / CLK_DIV || bad_pulse !== 0) begin
            miscompares++;
            $display("FAIL frame_totals: fs=%0d vs_low=%0d ticks=%0d bad=%0d want 2 %0d %0d 0",
                     fs_count, vs_low, tick_count, bad_pulse, 2 * VS * LINE, 2 * FRAME / CLK_DIV);
        end
    endtask

    // Mid-frame asynchronous reset after run_cycles edges, then a clean restart.
    task automatic test_async_reset(input int run_cycles, input int sub_delay);
        logic [24:0] exp;
        for (int i = 0; i < run_cycles; i++) begin
            tick_clk();
            exp = model(t);
            vectors++;
            if (dut_vec !== exp) begin
                miscompares++;
                $display("FAIL pre_reset t=%0d: got %h want %h", t, dut_vec, exp);
            end
        end
        #(sub_delay);
        reset = 1'b1;
        t = -1;
        #1;
        exp = model(-1);
        vectors++;
        if (dut_vec !== exp) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", dut_vec, exp);
        end
        tick_clk();
        vectors++;
        if (dut_vec !== exp) begin
            miscompares++;
            $display("FAIL reset_held: got %h want %h", dut_vec, exp);
        end
        release_reset();
        for (int i = 0; i < 8; i++) begin
            tick_clk();
            exp = model(t);
            vectors++;
            if (dut_vec !== exp) begin
                miscompares++;
                $display("FAIL restart t=%0d: got %h want %h", t, dut_vec, exp);
            end
        end
    endtask

    // Random run lengths and reset instants across the frame.
    task automatic test_random_resets();
        for (int k = 0; k < 4; k++) begin
            test_async_reset(int'($urandom_range(1, 2 * FRAME)), int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        t = -1;
        test_reset();
        test_first_cycles();
        test_line();
        test_frames();
        // Middle of the visible area: row VA/2, column HA/2, one clk into it.
        test_async_reset((((VA / 2) * HT + HA / 2) * CLK_DIV + 1) - t, 2);
        test_random_resets();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $finish;
    end

endmodule

// File: doc/display_timing.md
DISPLAY_TIMING -- requirements
Module: display_timing

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate); SHALL be >= 2.
REQ-002 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch/sync/back porch in pixels.
REQ-004 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-005 Parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch/sync/back porch in lines.
REQ-006 clk  in  1  single system clock; all state SHALL change only on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pix_tick  out  1  one-clk strobe marking each pixel-counter advance.
REQ-009 pixel_column  out  10  current horizontal count, 0..H_TOTAL-1.
REQ-010 pixel_row  out  10  current vertical count, 0..V_TOTAL-1.
REQ-011 video_on  out  1  high while position is visible; drives the Colorizer enableVideo input.
REQ-012 horiz_sync  out  1  active-low horizontal sync.
REQ-013 vert_sync  out  1  active-low vertical sync.
REQ-014 frame_start  out  1  one-clk pulse when position (0,0) begins a new frame.

Function
REQ-015 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525 default).
REQ-016 Prescaler SHALL count 0..CLK_DIV-1 every clk, wrapping to 0.
REQ-017 pix_tick SHALL be high for exactly the clk cycle in which the prescaler equals CLK_DIV-1.
REQ-018 pixel_column SHALL increment on each clk edge where pix_tick is high, wrapping H_TOTAL-1 -> 0.
REQ-019 pixel_row SHALL increment only on the edge where pixel_column wraps, wrapping V_TOTAL-1 -> 0.
REQ-020 Simultaneous column and row wrap SHALL yield (0,0) on one edge; no intermediate value SHALL be visible.
REQ-021 video_on SHALL be 1 iff pixel_column < H_ACTIVE and pixel_row < V_ACTIVE.
REQ-022 horiz_sync SHALL be 0 iff pixel_column is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 default).
REQ-023 vert_sync SHALL be 0 iff pixel_row is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 default).
REQ-024 video_on, horiz_sync, vert_sync SHALL be flops decoded from next-state counter values, so that all outputs change on the same edge as the counters and are glitch-free.
REQ-025 frame_start SHALL be high for exactly one clk: the cycle immediately after the edge on which the counters wrap (H_TOTAL-1,V_TOTAL-1) -> (0,0).
REQ-026 frame_start SHALL NOT assert on reset exit; the first pulse SHALL follow the first complete frame.
REQ-027 Counter widths SHALL be 10 bits; values >= H_TOTAL or >= V_TOTAL SHALL never occur.

Reset
REQ-028 While reset is high: prescaler=0, pixel_column=0, pixel_row=0, pix_tick=0, video_on=0, horiz_sync=1, vert_sync=1, frame_start=0.
REQ-029 Reset asserted mid-frame SHALL force the REQ-028 values immediately, without waiting for clk.
REQ-030 After reset deassert, first clk edge SHALL set video_on=1 (position (0,0)); first pix_tick SHALL occur in cycle CLK_DIV-1; the first column increment SHALL occur on the following edge.

Verification
REQ-031 Release reset, run 8 clk -> pix_tick high in cycles 3 and 7; pixel_column 0 -> 1 -> 2; video_on=1; both syncs=1.
REQ-032 Run one line -> horiz_sync low for 384 consecutive clk starting at column 656; line period 3200 clk; video_on falls at column 640.
REQ-033 Run to line end -> on column wrap 799 -> 0, pixel_row increments by exactly 1; no pix_tick gaps or doubles.
REQ-034 Run two full frames -> vert_sync low for 6400 clk at rows 490..491; frame_start pulses exactly once per 1,680,000 clk; pulses one clk wide; pixel (0,0) follows (799,524).
REQ-035 Assert reset asynchronously at row 300, column 400 (between clk edges) -> outputs match REQ-028 before the next clk edge; after release, timing restarts per REQ-031.
REQ-036 Continuous check over all frames -> video_on never high with column >= 640 or row >= 480; counters never exceed 799/524.
